// File: rtl/mcadd_pkg.sv
// rtl/mcadd_pkg.sv - shared states and sizing helpers for the multi-cycle adder
package mcadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a one-digit adder still keeps a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/my_adder_slice.sv
// rtl/my_adder_slice.sv - DIGIT-bit combinational ripple adder slice (MCADD_OVF_EN adds c_msb)
module my_adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
`ifdef MCADD_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < DIGIT; g++) begin : g_bit
        assign s[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end

    assign cout = c[DIGIT];

`ifdef MCADD_OVF_EN
    assign c_msb = c[DIGIT-1];
`endif

endmodule

// File: rtl/my_multicycle_adder.sv
// rtl/my_multicycle_adder.sv - WIDTH-bit adder computing DIGIT bits per clock (MCADD_OVF_EN adds ovf)
module my_multicycle_adder
    import mcadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef MCADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $fatal(1, "my_multicycle_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] ds;
    logic             dc;
    logic             last;
    logic             accept;

    assign in_ready  = resetn & ((state == IDLE) | ((state == DONE) & out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(N - 1));

    always_comb begin
        da = opa[int'(cnt) * DIGIT +: DIGIT];
        db = opb[int'(cnt) * DIGIT +: DIGIT];
    end

    // Partial result with the current digit merged in, so the final edge can publish it directly.
    always_comb begin
        r_next = r;
        r_next[int'(cnt) * DIGIT +: DIGIT] = ds;
    end

`ifdef MCADD_OVF_EN
    logic dmsb;

    my_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (da),
        .b     (db),
        .cin   (carry),
        .s     (ds),
        .cout  (dc),
        .c_msb (dmsb)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= dmsb ^ dc;
        end
    end
`else
    my_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (da),
        .b    (db),
        .cin  (carry),
        .s    (ds),
        .cout (dc)
    );
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            r     <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= dc;
                    r     <= r_next;
                    if (last) begin
                        s     <= r_next;
                        cout  <= dc;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            opa   <= a;
                            opb   <= b;
                            carry <= cin;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_multicycle_adder.sv
// tb/tb_my_multicycle_adder.sv - directed self-checking bench (MCADD_OVF_EN enables ovf checks)
module tb_my_multicycle_adder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        cout;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        cin1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [15:0] s1;
    logic        cout1;

`ifdef MCADD_OVF_EN
    logic        ovf;
    logic        ovf1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    my_multicycle_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef MCADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    my_multicycle_adder #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .s         (s1),
        .cout      (cout1)
`ifdef MCADD_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        int guard;
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        guard = 0;
        #1;
        while (in_ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] es, input logic ec, input logic eo);
        checks++;
        if (out_valid !== 1'b1 || s !== es || cout !== ec) begin
            errors++;
            $display("FAIL %s: out_valid=%b s=%h cout=%b required out_valid=1 s=%h cout=%b",
                     name, out_valid, s, cout, es, ec);
        end
`ifdef MCADD_OVF_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s_ovf: ovf=%b required %b", name, ovf, eo);
        end
`else
        if (eo === 1'bx) $display("note: %s", name);
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: in_ready=%b in_ready1=%b required 0", in_ready, in_ready1);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (s !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: s=%h cout=%b out_valid=%b in_ready=%b required 0 0 0 1",
                     s, cout, out_valid, in_ready);
        end
        checks++;
        if (s1 !== 16'h0 || cout1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_n1: s=%h cout=%b out_valid=%b in_ready=%b required 0 0 0 1",
                     s1, cout1, out_valid1, in_ready1);
        end
`ifdef MCADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b required 0", ovf);
        end
`endif
    endtask

    task automatic test_carry_wrap();
        int cyc;
        do_accept(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL wrap_latency: cycles=%0d required 4", cyc);
        end
        check_result("wrap", 16'h0000, 1'b1, 1'b0);
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL wrap_idle: out_valid=%b in_ready=%b s=%h cout=%b required 0 1 0000 1",
                     out_valid, in_ready, s, cout);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        do_accept(16'h7FFF, 16'h0001, 1'b0);
        wait_done(cyc);
        check_result("pos_ovf", 16'h8000, 1'b0, 1'b1);
        consume();
        do_accept(16'h8000, 16'h8000, 1'b0);
        wait_done(cyc);
        check_result("neg_ovf", 16'h0000, 1'b1, 1'b1);
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        do_accept(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(cyc);
        check_result("bp_first", 16'h1000, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 16'h1000 || cout !== 1'b0) bad++;
`ifdef MCADD_OVF_EN
            if (ovf !== 1'b0) bad++;
`endif
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (last s=%h in_ready=%b)", bad, s, in_ready);
        end
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_same_edge_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || s !== 16'h1000) begin
            errors++;
            $display("FAIL bp_run: out_valid=%b s=%h required 0 1000", out_valid, s);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL bp_latency: cycles=%0d required 4", cyc);
        end
        check_result("bp_second", 16'h5556, 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        do_accept(16'hFFFF, 16'h0001, 1'b0);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        checks++;
        if (s !== 16'h0 || cout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: s=%h cout=%b out_valid=%b in_ready=%b required 0 0 0 0",
                     s, cout, out_valid, in_ready);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || s !== 16'h0) begin
            errors++;
            $display("FAIL midrun_discard: out_valid=%b s=%h required 0 0000", out_valid, s);
        end
        do_accept(16'h0003, 16'h0004, 1'b0);
        wait_done(cyc);
        check_result("after_reset", 16'h0007, 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_isolation();
        int cyc;
        do_accept(16'h00FF, 16'h0F01, 1'b0);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            tick();
            cyc++;
        end
        check_result("isolation", 16'h1000, 1'b0, 1'b0);
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        do_accept(16'h0001, 16'h0002, 1'b0);
        wait_done(cyc);
        check_result("b2b_first", 16'h0003, 1'b0, 1'b0);
        do_accept(16'h0005, 16'h0006, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL b2b_latency: cycles=%0d required 4", cyc);
        end
        check_result("b2b_second", 16'h000B, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_single_digit();
        int cyc;
        a1 = 16'hAAAA;
        b1 = 16'h5555;
        cin1 = 1'b1;
        in_valid1 = 1'b1;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_ready: in_ready=%b required 1", in_ready1);
        end
        tick();
        in_valid1 = 1'b0;
        cyc = 0;
        while (out_valid1 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 1 || s1 !== 16'h0000 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_result: cycles=%0d s=%h cout=%b required 1 0000 1", cyc, s1, cout1);
        end
`ifdef MCADD_OVF_EN
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_ovf: ovf=%b required 0", ovf1);
        end
`endif
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_idle: out_valid=%b in_ready=%b required 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_isolation();
        test_back_to_back();
        test_single_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/my_multicycle_adder.md
# my_multicycle_adder

Multi-cycle, parametrised adder that computes a WIDTH-bit sum DIGIT bits per clock. It reuses one DIGIT-bit adder slice and keeps a registered carry between digits. Operands enter through a valid/ready handshake and the result leaves through one. It is the sequential successor to the single-bit combinational full adder, for datapaths where a wide ripple adder does not fit the area budget or the cycle time.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of DIGIT
- DIGIT, 4, bits added per cycle; N = WIDTH/DIGIT cycles per operation; DIGIT == WIDTH is legal (N = 1)
- CLK  in  1  single clock; all state changes on the rising edge
- RESETN  in  1  reset, synchronous, active-low
- IN_VALID  in  1  operands A, B and CIN are presented
- IN_READY  out  1  block accepts operands this cycle
- A  in  WIDTH  operand A, unsigned or two's complement
- B  in  WIDTH  operand B
- CIN  in  1  carry-in to digit 0
- OUT_VALID  out  1  S and COUT hold a completed result
- OUT_READY  in  1  consumer accepts the result
- S  out  WIDTH  sum, registered
- COUT  out  1  carry out of the MSB, registered
- OVF  out  1  signed overflow, registered; present only with MCADD_OVF_EN

## Operation
- States:
  - IDLE: IN_READY = 1.
  - RUN: IN_READY = 0, OUT_VALID = 0.
  - DONE: OUT_VALID = 1; IN_READY = OUT_READY.
- Accept: IN_VALID & IN_READY. On accept, register A, B and CIN into the operand/carry registers, clear the digit counter and go to RUN. Operand pins are ignored after the accept edge.
- RUN, one digit per edge:
  - digit i = counter;
  - {c, r[i*DIGIT +: DIGIT]} = A[i] + B[i] + carry;
  - carry <= c;
  - counter increments.
- After digit N-1: S <= r, COUT <= final carry, OVF <= carry into MSB ^ COUT; go to DONE.
- DONE:
  - OUT_READY = 0: hold S, COUT and OVF stable.
  - OUT_READY = 1 and IN_VALID = 0: go to IDLE.
  - OUT_READY = 1 and IN_VALID = 1: accept the new operands on the same edge and go directly to RUN.
- S, COUT and OVF change only on the RUN to DONE edge. They keep the previous result during IDLE and RUN.
- Counter width: max(1, $clog2(N)). The counter never wraps past N-1.
- All arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset: RESETN low at an edge gives, from the next cycle:
  - state = IDLE, counter = 0, carry = 0;
  - S = 0, COUT = 0, OVF = 0;
  - OUT_VALID = 0, IN_READY = 1.
- IN_READY is forced to 0 while RESETN is low.
- Reset mid-RUN or mid-DONE discards the operation. No result is produced.
- Latency: operands accepted at edge k give OUT_VALID = 1 in the cycle after edge k+N.
- Throughput with OUT_READY held at 1: one operation every N+1 cycles.
- IN_READY is a combinational decode of state and OUT_READY. It has no dependence on IN_VALID.
- OUT_VALID is a pure state decode and does not depend on OUT_READY.

## Configuration
- MCADD_OVF_EN defined:
  - OVF port and its register exist;
  - OVF = 1 when the signed interpretation overflows (pos+pos giving neg, or neg+neg giving pos);
  - OVF is reset to 0 and updated with S.
- MCADD_OVF_EN undefined: no OVF port and no carry-into-MSB tap. All other behaviour is identical.

## Structure
- Shared package mcadd_pkg:
  - state enum {IDLE, RUN, DONE};
  - a localparam function computing counter width from WIDTH and DIGIT.
- One sub-module, my_adder_slice: combinational DIGIT-bit ripple adder with a, b, cin inputs and s, cout outputs. It also exports the carry into its MSB for the overflow tap.
- Elaboration check: WIDTH % DIGIT != 0 is a fatal error.

## Test plan
- WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, CIN=0 → S=0x0000, COUT=1, OVF=0, with OUT_VALID exactly 4 cycles after accept.
- A=0x7FFF, B=0x0001, CIN=0 → S=0x8000, COUT=0, OVF=1. Also A=0x8000, B=0x8000 → S=0x0000, COUT=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 10 cycles in DONE → S, COUT and OVF stay stable, IN_READY=0. Then drive OUT_READY=1 with IN_VALID=1, A=0x1234, B=0x4321, CIN=1 → accepted on the same edge, next result S=0x5556, COUT=0.
- Reset mid-RUN: RESETN=0 for 1 cycle during digit 2 → next cycle all outputs are 0, OUT_VALID=0, IN_READY=1. Then 0x0003+0x0004 → S=0x0007.
- Operand isolation: change A and B on every RUN cycle after accepting 0x00FF+0x0F01 → S=0x1000, COUT=0, unaffected by the pin changes.
- DIGIT=16 (N=1): 0xAAAA+0x5555, CIN=1 → S=0x0000, COUT=1, OUT_VALID 1 cycle after accept.
